kbd_event_scheduler: RTL and testbench

Buffers and paces decoded keyboard codes between the PS/2 keyboard controller and the VGA drawing logic. It accepts one 6-bit key code per strobe and suppresses held-key repeats faster than a programmable interval. Accepted codes go into a small FIFO, which is drained by the consumer through a valid/ready handshake. Overflow is reported with a sticky flag.

---
 rtl/kbd_pkg.sv | 22 ++
 rtl/kbd_fifo.sv | 77 +++++++
 rtl/kbd_event_scheduler.sv | 130 +++++++++++++
 tb/tb_kbd_event_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: definitions shared by the keyboard path (PS/2 decode consumers,
// the event scheduler and the VGA drawing side).
//   KEY_CODE_W   - width of a decoded key code
//   KEY_NONE     - code meaning "release / no key"
//   filt_state_t - repeat-filter state encoding
//   is_key_none  - helper that tests a code against KEY_NONE
package kbd_pkg;

  localparam int KEY_CODE_W = 6;
  localparam logic [KEY_CODE_W-1:0] KEY_NONE = 6'd0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // no key held
    HELD      = 2'd1,  // repeat timer running
    REPEAT_OK = 2'd2   // repeat interval has elapsed
  } filt_state_t;

  function automatic logic is_key_none(input logic [KEY_CODE_W-1:0] code);
    return code == KEY_NONE;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: generic synchronous first-word-fall-through FIFO.
// Ports:
//   i_clk, i_srst      - clock, synchronous active-high reset
//   i_push, i_data     - write request and data
//   i_pop              - read request (ignored while empty)
//   o_data             - head entry, forced to zero while empty
//   o_full, o_empty    - status flags
//   o_level            - number of stored entries, 0..DEPTH
// A push on a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is discarded (the caller decides what that means).
module kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/kbd_event_scheduler.sv
// kbd_event_scheduler: paces decoded keyboard codes toward the VGA side.
// Held-key repeats arriving faster than REPEAT_CYCLES are suppressed; the
// surviving codes are queued in a FWFT FIFO drained by valid/ready.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   keyCode, keyStrobe  - decoded code, valid during the one-cycle strobe
//   outReady            - consumer takes outCode this cycle
//   clrOverflow         - clears the sticky overflow flag
//   outValid, outCode   - FIFO head (outCode is zero when empty)
//   fifoLevel           - number of queued codes
//   overflow            - sticky: an eligible code was lost to a full FIFO
module kbd_event_scheduler
  import kbd_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int REPEAT_CYCLES = 25_000_000,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [KEY_CODE_W-1:0] keyCode,
  input  logic                  keyStrobe,
  input  logic                  outReady,
  input  logic                  clrOverflow,
  output logic                  outValid,
  output logic [KEY_CODE_W-1:0] outCode,
  output logic [LVL_W-1:0]      fifoLevel,
  output logic                  overflow
);

  localparam int TIMER_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(REPEAT_CYCLES - 1);

  filt_state_t           r_state;
  logic [KEY_CODE_W-1:0] r_last_code;
  logic [TIMER_W-1:0]    r_timer;
  logic                  r_overflow;

  logic                  w_is_none;
  logic                  w_same_code;
  logic                  w_expired;
  logic                  w_eligible;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [KEY_CODE_W-1:0] w_fifo_data;
  logic [LVL_W-1:0]      w_fifo_level;

  assign w_is_none   = is_key_none(keyCode);
  assign w_same_code = (keyCode == r_last_code);

  // The timer holds TIMER_MAX during the cycle in which REPEAT_CYCLES cycles
  // have elapsed since acceptance, so that cycle already counts as expired;
  // the state register catches up to REPEAT_OK on the following edge.
  assign w_expired = (r_state == REPEAT_OK) ||
                     ((r_state == HELD) && (r_timer == TIMER_MAX));

  assign w_eligible = keyStrobe && !w_is_none &&
                      ((r_state == IDLE) || !w_same_code || w_expired);

  assign w_pop  = !w_fifo_empty && outReady;
  assign w_drop = w_eligible && w_fifo_full && !w_pop;

  // Repeat filter, timer and overflow flag. A dropped code still updates the
  // filter so the same held key is not retried every strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_code <= KEY_NONE;
      r_timer     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (keyStrobe && w_is_none) begin
        r_state     <= IDLE;
        r_last_code <= KEY_NONE;
        r_timer     <= '0;
      end else if (w_eligible) begin
        r_state     <= HELD;
        r_last_code <= keyCode;
        r_timer     <= '0;
      end else begin
        unique case (r_state)
          HELD: begin
            if (r_timer == TIMER_MAX) begin
              r_state <= REPEAT_OK;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          IDLE, REPEAT_OK: begin
            r_state <= r_state;
          end
          default: begin
            r_state <= IDLE;
            r_timer <= '0;
          end
        endcase
      end

      // A new overflow wins over a simultaneous clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clrOverflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  kbd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .i_clk   (clock),
    .i_srst  (reset),
    .i_push  (w_eligible),
    .i_data  (keyCode),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  assign outValid  = !w_fifo_empty;
  assign outCode   = w_fifo_data;
  assign fifoLevel = w_fifo_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_kbd_event_scheduler.sv
module tb_kbd_event_scheduler;

  localparam int DEPTH = 4;
  localparam int REP   = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [5:0]    keyCode;
  logic          keyStrobe;
  logic          outReady;
  logic          clrOverflow;
  logic          outValid;
  logic [5:0]    outCode;
  logic [LW-1:0] fifoLevel;
  logic          overflow;

  always #5 clock = ~clock;

  kbd_event_scheduler #(
    .DEPTH         (DEPTH),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .keyCode     (keyCode),
    .keyStrobe   (keyStrobe),
    .outReady    (outReady),
    .clrOverflow (clrOverflow),
    .outValid    (outValid),
    .outCode     (outCode),
    .fifoLevel   (fifoLevel),
    .overflow    (overflow)
  );

  typedef struct {
    logic       rst;
    logic       stb;
    logic [5:0] code;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [5:0] c;
    int         lvl;
    logic       o;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, input logic stb, input int code,
                     input logic rdy, input logic clr,
                     input logic v, input int c, input int lvl, input logic o);
    vec_t t;
    t.rst = rst; t.stb = stb; t.code = 6'(code); t.rdy = rdy; t.clr = clr;
    t.v = v; t.c = 6'(c); t.lvl = lvl; t.o = o;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called #1 after a rising edge), clock it in,
  // then return #1 after the edge with inputs back to idle.
  task automatic cycle(input logic rst, input logic stb, input logic [5:0] code,
                       input logic rdy, input logic clr);
    reset = rst; keyStrobe = stb; keyCode = code; outReady = rdy; clrOverflow = clr;
    @(posedge clock);
    #1;
    reset = 1'b0; keyStrobe = 1'b0; keyCode = 6'd0; outReady = 1'b0; clrOverflow = 1'b0;
  endtask

  initial begin
    logic [5:0] drained [$];
    int         budget;

    reset = 1'b1; keyStrobe = 1'b0; keyCode = 6'd0; outReady = 1'b0; clrOverflow = 1'b0;

    //   rst stb code rdy clr |  v  c  lvl o
    add(1, 0,  0, 0, 0,   0,  0, 0, 0);  // 0 reset state
    add(0, 1, 12, 0, 0,   1, 12, 1, 0);  // 1 single key
    add(0, 0,  0, 1, 0,   0,  0, 0, 0);  // 2 pop it
    add(0, 1,  5, 0, 0,   1,  5, 1, 0);  // 3 t0: accept 5
    add(0, 0,  0, 0, 0,   1,  5, 1, 0);  // 4
    add(0, 0,  0, 0, 0,   1,  5, 1, 0);  // 5
    add(0, 1,  5, 0, 0,   1,  5, 1, 0);  // 6 t0+3: repeat dropped
    add(0, 0,  0, 0, 0,   1,  5, 1, 0);  // 7
    add(0, 0,  0, 0, 0,   1,  5, 1, 0);  // 8
    add(0, 0,  0, 0, 0,   1,  5, 1, 0);  // 9
    add(0, 1,  5, 0, 0,   1,  5, 1, 0);  // 10 t0+7: still too early
    add(0, 1,  5, 0, 0,   1,  5, 2, 0);  // 11 t0+8: accepted (timer restarts)
    add(0, 0,  0, 1, 0,   1,  5, 1, 0);  // 12
    add(0, 0,  0, 1, 0,   0,  0, 0, 0);  // 13
    add(0, 1,  0, 0, 0,   0,  0, 0, 0);  // 14 release, not queued
    add(0, 1,  5, 0, 0,   1,  5, 1, 0);  // 15
    add(0, 1,  0, 0, 0,   1,  5, 1, 0);  // 16 release between presses
    add(0, 1,  5, 0, 0,   1,  5, 2, 0);  // 17 accepted after release
    add(0, 0,  0, 1, 0,   1,  5, 1, 0);  // 18
    add(0, 0,  0, 1, 0,   0,  0, 0, 0);  // 19
    add(0, 1,  1, 0, 0,   1,  1, 1, 0);  // 20 fill
    add(0, 1,  2, 0, 0,   1,  1, 2, 0);  // 21
    add(0, 1,  3, 0, 0,   1,  1, 3, 0);  // 22
    add(0, 1,  4, 0, 0,   1,  1, 4, 0);  // 23 full
    add(0, 1,  7, 0, 0,   1,  1, 4, 1);  // 24 overflow
    add(0, 0,  0, 0, 0,   1,  1, 4, 1);  // 25 sticky
    add(0, 0,  0, 0, 1,   1,  1, 4, 0);  // 26 cleared
    add(0, 0,  0, 1, 0,   1,  2, 3, 0);  // 27 drain 1
    add(0, 0,  0, 1, 0,   1,  3, 2, 0);  // 28 drain 2
    add(0, 0,  0, 1, 0,   1,  4, 1, 0);  // 29 drain 3
    add(0, 0,  0, 1, 0,   0,  0, 0, 0);  // 30 drain 4
    add(0, 1,  1, 0, 0,   1,  1, 1, 0);  // 31 fill again
    add(0, 1,  2, 0, 0,   1,  1, 2, 0);  // 32
    add(0, 1,  3, 0, 0,   1,  1, 3, 0);  // 33
    add(0, 1,  4, 0, 0,   1,  1, 4, 0);  // 34
    add(0, 1,  9, 1, 0,   1,  2, 4, 0);  // 35 push+pop on full
    add(0, 0,  0, 1, 0,   1,  3, 3, 0);  // 36
    add(0, 0,  0, 1, 0,   1,  4, 2, 0);  // 37
    add(0, 0,  0, 1, 0,   1,  9, 1, 0);  // 38
    add(0, 0,  0, 1, 0,   0,  0, 0, 0);  // 39
    add(0, 1,  1, 0, 0,   1,  1, 1, 0);  // 40
    add(0, 1,  2, 0, 0,   1,  1, 2, 0);  // 41
    add(0, 1,  3, 0, 0,   1,  1, 3, 0);  // 42
    add(0, 1,  4, 0, 0,   1,  1, 4, 0);  // 43
    add(0, 1,  7, 0, 1,   1,  1, 4, 1);  // 44 set beats clear
    add(0, 0,  0, 0, 1,   1,  1, 4, 0);  // 45
    add(0, 0,  0, 1, 0,   1,  2, 3, 0);  // 46
    add(0, 0,  0, 1, 0,   1,  3, 2, 0);  // 47
    add(0, 0,  0, 1, 0,   1,  4, 1, 0);  // 48
    add(0, 0,  0, 1, 0,   0,  0, 0, 0);  // 49
    add(0, 1,  8, 1, 0,   1,  8, 1, 0);  // 50 push+pop on empty
    add(0, 0,  0, 1, 0,   0,  0, 0, 0);  // 51
    add(0, 1, 10, 0, 0,   1, 10, 1, 0);  // 52
    add(0, 1, 11, 0, 0,   1, 10, 2, 0);  // 53
    add(0, 1, 12, 0, 0,   1, 10, 3, 0);  // 54
    add(0, 1, 13, 0, 0,   1, 10, 4, 0);  // 55
    add(0, 1, 14, 0, 0,   1, 10, 4, 1);  // 56 dropped, 14 now held
    add(1, 1, 20, 0, 0,   0,  0, 0, 0);  // 57 reset, strobe ignored
    add(0, 1, 14, 0, 0,   1, 14, 1, 0);  // 58 held code accepted after reset
    add(0, 1, 14, 0, 0,   1, 14, 1, 0);  // 59 repeat dropped again

    @(posedge clock);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].rst, vq[i].stb, vq[i].code, vq[i].rdy, vq[i].clr);
      $display("step %0d: rst=%0d stb=%0d code=%0d rdy=%0d clr=%0d -> valid=%0d code=%0d level=%0d ovf=%0d",
               i, vq[i].rst, vq[i].stb, vq[i].code, vq[i].rdy, vq[i].clr,
               outValid, outCode, fifoLevel, overflow);
      chk("outValid",  i, 32'(outValid),  32'(vq[i].v));
      chk("outCode",   i, 32'(outCode),   32'(vq[i].c));
      chk("fifoLevel", i, 32'(fifoLevel), 32'(vq[i].lvl));
      chk("overflow",  i, 32'(overflow),  32'(vq[i].o));
    end

    // Long hold: after well beyond REPEAT_CYCLES the filter sits in REPEAT_OK
    // and the same code is accepted again.
    for (int i = 0; i < 3 * REP; i++) cycle(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 6'd14, 1'b0, 1'b0);
    $display("long hold: strobe 14 -> level=%0d", fifoLevel);
    chk("long_hold_level", 100, 32'(fifoLevel), 32'd2);

    // Bounded drain: expect exactly 14, 14.
    budget = 0;
    while (outValid === 1'b1 && budget < 8) begin
      drained.push_back(outCode);
      cycle(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
      budget++;
      $display("drain %0d: popped %0d, level now %0d", budget, drained[drained.size()-1], fifoLevel);
    end
    chk("drain_terminated", 101, 32'(outValid), 32'd0);
    chk("drain_count",      102, 32'(drained.size()), 32'd2);
    for (int i = 0; i < drained.size() && i < 2; i++)
      chk("drain_code", 103 + i, 32'(drained[i]), 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
